// File: rtl/lfsr_pattern_gen.sv
// LBIST pattern source: loadable-polynomial LFSR (Fibonacci or Galois) with a counted run and start/busy/done handshake.
// Optional all-zero lockup recovery is compiled in with LFSR_LOCKUP_GUARD_EN.
module lfsr_pattern_gen #(
    parameter int             BITS     = 8,
    parameter int             CNT_W    = 16,
    parameter int             GALOIS   = 0,
    parameter logic [BITS-1:0] DEF_POLY = 8'hB8,
    parameter logic [BITS-1:0] DEF_SEED = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [BITS-1:0]  poly_in,
    input  logic [BITS-1:0]  seed_in,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             valid,
    output logic [BITS-1:0]  pattern,
    output logic             done,
    output logic             wrap,
    output logic             lockup
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [BITS-1:0]   poly_q, poly_d;
    logic [BITS-1:0]   seed_q, seed_d;
    logic [BITS-1:0]   pattern_q, pattern_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic [BITS-1:0]   step;
    logic [BITS-1:0]   advance;
    logic              zero_hit;

    generate
        if (GALOIS != 0) begin : g_galois
            assign step = {1'b0, pattern_q[BITS-1:1]} ^ ({BITS{pattern_q[0]}} & poly_q);
        end else begin : g_fib
            logic fb;
            assign fb   = ^(poly_q & pattern_q);
            assign step = {fb, pattern_q[BITS-1:1]};
        end
    endgenerate

`ifdef LFSR_LOCKUP_GUARD_EN
    // An all-zero state is a dead end for XOR feedback; restart from the seed instead.
    assign zero_hit = (state_q == RUN) && (pattern_q == '0);
    assign advance  = zero_hit ? seed_q : step;
`else
    assign zero_hit = 1'b0;
    assign advance  = step;
`endif

    always_comb begin
        state_d   = state_q;
        poly_d    = poly_q;
        seed_d    = seed_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    poly_d    = poly_in;
                    seed_d    = seed_in;
                    pattern_d = seed_in;
                end
                if (start) begin
                    state_d   = RUN;
                    pattern_d = load_en ? seed_in : seed_q;
                    cnt_d     = '0;
                    n_d       = num_patterns;
                end
            end
            RUN: begin
                // Abort wins over count completion and freezes the pattern.
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    pattern_d = advance;
                    cnt_d     = cnt_q + CNT_ONE;
                    if ((n_q != '0) && (cnt_q == n_q - CNT_ONE)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            poly_q    <= DEF_POLY;
            seed_q    <= DEF_SEED;
            pattern_q <= DEF_SEED;
            cnt_q     <= '0;
            n_q       <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            poly_q    <= poly_d;
            seed_q    <= seed_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign done    = done_q;
    assign pattern = pattern_q;
    assign wrap    = (state_q == RUN) && (step == seed_q);
    assign lockup  = zero_hit;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Self-checking bench for lfsr_pattern_gen: 8-bit Fibonacci and Galois instances share stimulus, a 4-bit instance covers the reference sequence.
module tb_lfsr_pattern_gen;

`ifdef LFSR_LOCKUP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        load_en = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0]  poly_in = '0, seed_in = '0;
    logic [15:0] num_patterns = '0;
    logic        busy_f, valid_f, done_f, wrap_f, lockup_f;
    logic        busy_g, valid_g, done_g, wrap_g, lockup_g;
    logic [7:0]  pattern_f, pattern_g;

    logic        load4 = 1'b0, start4 = 1'b0, stop4 = 1'b0;
    logic [3:0]  poly4 = '0, seed4 = '0;
    logic [7:0]  num4 = '0;
    logic        busy4, valid4, done4, wrap4, lockup4;
    logic [3:0]  pattern4;

    lfsr_pattern_gen #(.BITS(8), .CNT_W(16), .GALOIS(0), .DEF_POLY(8'hB8), .DEF_SEED(8'h01)) dut_f (
        .clk(clk), .rst(rst), .load_en(load_en), .poly_in(poly_in), .seed_in(seed_in),
        .num_patterns(num_patterns), .start(start), .stop(stop), .busy(busy_f), .valid(valid_f),
        .pattern(pattern_f), .done(done_f), .wrap(wrap_f), .lockup(lockup_f));

    lfsr_pattern_gen #(.BITS(8), .CNT_W(16), .GALOIS(1), .DEF_POLY(8'hB8), .DEF_SEED(8'h01)) dut_g (
        .clk(clk), .rst(rst), .load_en(load_en), .poly_in(poly_in), .seed_in(seed_in),
        .num_patterns(num_patterns), .start(start), .stop(stop), .busy(busy_g), .valid(valid_g),
        .pattern(pattern_g), .done(done_g), .wrap(wrap_g), .lockup(lockup_g));

    lfsr_pattern_gen #(.BITS(4), .CNT_W(8), .GALOIS(0), .DEF_POLY(4'h9), .DEF_SEED(4'h8)) dut4 (
        .clk(clk), .rst(rst), .load_en(load4), .poly_in(poly4), .seed_in(seed4),
        .num_patterns(num4), .start(start4), .stop(stop4), .busy(busy4), .valid(valid4),
        .pattern(pattern4), .done(done4), .wrap(wrap4), .lockup(lockup4));

    typedef struct {
        logic [7:0] pat;
        logic       wrap;
        logic       lock;
    } exp_t;

    typedef struct {
        logic [7:0]  poly;
        logic [7:0]  seed;
        logic [15:0] n;
        logic [7:0]  exp_second;
    } vec_t;

    exp_t q_f[$];
    exp_t q_g[$];
    int   checks = 0;
    int   errors = 0;
    int   idx_f = 0;
    logic [7:0] second_f = '0;
    logic [7:0] held;
    logic [3:0] seq4 [15];
    vec_t vecs [4];

    function automatic logic [7:0] fib8(input logic [7:0] poly, input logic [7:0] p);
        return {^(poly & p), p[7:1]};
    endfunction

    function automatic logic [7:0] gal8(input logic [7:0] poly, input logic [7:0] p);
        return {1'b0, p[7:1]} ^ ({8{p[0]}} & poly);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_run(input logic [7:0] poly, input logic [7:0] seed, input int n);
        exp_t e;
        logic [7:0] pf = seed;
        logic [7:0] pg = seed;
        for (int i = 0; i < n; i++) begin
            e.pat  = pf;
            e.wrap = (fib8(poly, pf) == seed);
            e.lock = GUARD && (pf == 8'h00);
            q_f.push_back(e);
            pf = e.lock ? seed : fib8(poly, pf);
            e.pat  = pg;
            e.wrap = (gal8(poly, pg) == seed);
            e.lock = GUARD && (pg == 8'h00);
            q_g.push_back(e);
            pg = e.lock ? seed : gal8(poly, pg);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (valid_f === 1'b1) begin
            idx_f++;
            if (idx_f == 2) second_f = pattern_f;
            chk("sb_f_avail", 32'(q_f.size() > 0), 1);
            if (q_f.size() > 0) begin
                e = q_f.pop_front();
                chk("sb_f_pattern", 32'(pattern_f), 32'(e.pat));
                chk("sb_f_wrap", 32'(wrap_f), 32'(e.wrap));
                chk("sb_f_lockup", 32'(lockup_f), 32'(e.lock));
            end
        end
        if (valid_g === 1'b1) begin
            chk("sb_g_avail", 32'(q_g.size() > 0), 1);
            if (q_g.size() > 0) begin
                e = q_g.pop_front();
                chk("sb_g_pattern", 32'(pattern_g), 32'(e.pat));
                chk("sb_g_wrap", 32'(wrap_g), 32'(e.wrap));
            end
        end
    endtask

    // Caller is positioned at a negedge; start is driven immediately so runs can be back-to-back.
    task automatic run(input logic ld, input logic [7:0] poly, input logic [7:0] seed,
                       input logic [15:0] n, input logic [7:0] mpoly, input logic [7:0] mseed);
        load_en = ld; poly_in = poly; seed_in = seed; num_patterns = n; start = 1'b1;
        idx_f = 0;
        push_run(mpoly, mseed, int'(n));
        for (int i = 0; i < int'(n); i++) begin
            tick();
            if (i == 0) begin start = 1'b0; load_en = 1'b0; end
            chk("run_valid", 32'(valid_f), 1);
            chk("run_busy", 32'(busy_f), 1);
            chk("run_done_low", 32'(done_f), 0);
        end
        tick();
        chk("done_pulse", 32'(done_f), 1);
        chk("done_valid_low", 32'(valid_f), 0);
        chk("done_busy", 32'(busy_f), 1);
        chk("done_wrap_low", 32'(wrap_f), 0);
        chk("done_pulse_g", 32'(done_g), 1);
        tick();
        chk("idle_busy", 32'(busy_f), 0);
        chk("idle_done", 32'(done_f), 0);
        chk("idle_valid", 32'(valid_f), 0);
        chk("idle_busy_g", 32'(busy_g), 0);
    endtask

    initial begin
        seq4 = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b1011, 4'b0101, 4'b1010,
                 4'b1101, 4'b0110, 4'b0011, 4'b1001, 4'b0100, 4'b0010, 4'b0001};
        vecs[0] = '{poly: 8'hB8, seed: 8'h01, n: 16'd3, exp_second: 8'h00};
        vecs[1] = '{poly: 8'h8E, seed: 8'hA5, n: 16'd5, exp_second: 8'h52};
        vecs[2] = '{poly: 8'hB8, seed: 8'hFF, n: 16'd4, exp_second: 8'h7F};
        vecs[3] = '{poly: 8'h1D, seed: 8'h80, n: 16'd6, exp_second: 8'h40};

        #1 rst = 1'b1;
        #2;
        chk("reset_busy", 32'(busy_f), 0);
        chk("reset_valid", 32'(valid_f), 0);
        chk("reset_done", 32'(done_f), 0);
        chk("reset_wrap", 32'(wrap_f), 0);
        chk("reset_lockup", 32'(lockup_f), 0);
        chk("reset_pattern", 32'(pattern_f), 32'h01);
        chk("reset_pattern4", 32'(pattern4), 32'h8);
        @(negedge clk);
        rst = 1'b0;

        // Default polynomial/seed, 3 patterns, no load.
        run(1'b0, 8'h00, 8'h00, 16'd3, 8'hB8, 8'h01);
        chk("default_second", 32'(second_f), 32'h00);

        // Table runs are back-to-back with load and start in the same cycle.
        for (int v = 0; v < 4; v++) begin
            run(1'b1, vecs[v].poly, vecs[v].seed, vecs[v].n, vecs[v].poly, vecs[v].seed);
            chk("vec_second", 32'(second_f), 32'(vecs[v].exp_second));
        end

        // Load latency in IDLE.
        load_en = 1'b1; poly_in = 8'h8E; seed_in = 8'h3C;
        tick();
        load_en = 1'b0;
        chk("load_pattern", 32'(pattern_f), 32'h3C);
        chk("load_valid", 32'(valid_f), 0);
        chk("load_busy", 32'(busy_f), 0);

        // load_en held during a run must not change poly/seed.
        start = 1'b1; num_patterns = 16'd4;
        push_run(8'h8E, 8'h3C, 4);
        tick();
        start = 1'b0; load_en = 1'b1; poly_in = 8'h1D; seed_in = 8'h77;
        for (int i = 0; i < 4; i++) tick();
        chk("busy_load_done", 32'(done_f), 1);
        load_en = 1'b0;
        tick();
        run(1'b0, 8'h00, 8'h00, 16'd3, 8'h8E, 8'h3C);

        // Stop during the 5th valid cycle of a 10-pattern run.
        load_en = 1'b1; poly_in = 8'h8E; seed_in = 8'hA5; num_patterns = 16'd10; start = 1'b1;
        push_run(8'h8E, 8'hA5, 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin start = 1'b0; load_en = 1'b0; end
        end
        stop = 1'b1;
        held = pattern_f;
        tick();
        stop = 1'b0;
        chk("stop_valid", 32'(valid_f), 0);
        chk("stop_busy", 32'(busy_f), 0);
        chk("stop_done", 32'(done_f), 0);
        chk("stop_pattern_hold", 32'(pattern_f), 32'(held));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stop_no_done", 32'(done_f), 0);
            chk("stop_hold_more", 32'(pattern_f), 32'(held));
        end

        // Stop in the last counted cycle beats completion.
        start = 1'b1; num_patterns = 16'd3;
        push_run(8'h8E, 8'hA5, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) start = 1'b0;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_last_done", 32'(done_f), 0);
        chk("stop_last_busy", 32'(busy_f), 0);

        // Asynchronous reset between edges mid-run.
        load_en = 1'b1; poly_in = 8'h1D; seed_in = 8'h5A; num_patterns = 16'd10; start = 1'b1;
        push_run(8'h1D, 8'h5A, 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin start = 1'b0; load_en = 1'b0; end
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_f), 0);
        chk("arst_valid", 32'(valid_f), 0);
        chk("arst_done", 32'(done_f), 0);
        chk("arst_pattern", 32'(pattern_f), 32'h01);
        q_f.delete();
        q_g.delete();
        tick();
        rst = 1'b0;
        run(1'b0, 8'h00, 8'h00, 16'd2, 8'hB8, 8'h01);

        // 4-bit reference sequence in free-run mode.
        load4 = 1'b1; poly4 = 4'b1001; seed4 = 4'b1000; num4 = 8'd0; start4 = 1'b1;
        tick();
        load4 = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("seq4_pattern", 32'(pattern4), 32'(seq4[i % 15]));
            chk("seq4_wrap", 32'(wrap4), 32'((i % 15) == 14));
            chk("seq4_valid", 32'(valid4), 1);
            tick();
        end
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        chk("seq4_stop_busy", 32'(busy4), 0);

        // All-zero state: recovered to the seed with the guard, sticky without it.
        load4 = 1'b1; poly4 = 4'b1001; seed4 = 4'b0000; start4 = 1'b1;
        tick();
        load4 = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("zero_seed_pattern", 32'(pattern4), 0);
            chk("zero_seed_lockup", 32'(lockup4), 32'(GUARD));
            tick();
        end
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        load4 = 1'b1; poly4 = 4'b0000; seed4 = 4'b0001; start4 = 1'b1;
        tick();
        load4 = 1'b0; start4 = 1'b0;
        chk("zero_poly_p0", 32'(pattern4), 32'h1);
        chk("zero_poly_l0", 32'(lockup4), 0);
        tick();
        chk("zero_poly_p1", 32'(pattern4), 32'h0);
        chk("zero_poly_l1", 32'(lockup4), 32'(GUARD));
        tick();
        chk("zero_poly_p2", 32'(pattern4), GUARD ? 32'h1 : 32'h0);
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;

        chk("sb_f_empty", 32'(q_f.size()), 0);
        chk("sb_g_empty", 32'(q_g.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_pattern_gen.md
# lfsr_pattern_gen

Parametrised LBIST pattern source: an N-bit LFSR with a run-time loadable polynomial and seed, a selectable Fibonacci/Galois structure, a programmable pattern count, and a start/busy/done handshake. It drives scan-chain stimulus and tells the BIST controller when a run of patterns is finished. It flags the cycle where the sequence returns to its seed.

## Interface
Parameters:
- BITS, 8, LFSR width (≥3)
- CNT_W, 16, width of the pattern counter
- GALOIS, 0, 0 = Fibonacci (external XOR), 1 = Galois (internal XOR)
- DEF_POLY, 8'hB8, tap mask loaded at reset (bit i = tap on stage i)
- DEF_SEED, 8'h01, seed loaded at reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_en  in  1  load poly_in/seed_in (honoured only when busy=0)
- poly_in  in  BITS  new tap mask
- seed_in  in  BITS  new seed
- num_patterns  in  CNT_W  patterns per run; 0 = free-run until stop
- start  in  1  begin a run (honoured only in IDLE)
- stop  in  1  abort the run
- busy  out  1  FSM not in IDLE
- valid  out  1  pattern is valid this cycle
- pattern  out  BITS  current LFSR state
- done  out  1  one-cycle pulse, run completed by count
- wrap  out  1  one-cycle pulse, next state equals the seed (period complete)
- lockup  out  1  one-cycle pulse, all-zero state recovered (see Configuration)

## Operation
- Registers: poly_r, seed_r, pattern, cnt (CNT_W), n_r (latched num_patterns), FSM state.
- Fibonacci step: fb = XOR over i of (poly_r[i] & pattern[i]); next = {fb, pattern[BITS-1:1]}.
- Galois step: next = {1'b0, pattern[BITS-1:1]} ^ ({BITS{pattern[0]}} & poly_r).
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - load_en: poly_r←poly_in, seed_r←seed_in, pattern←seed_in.
    - start: pattern←seed_r, cnt←0, n_r←num_patterns, go to RUN.
    - load_en and start in the same cycle: the load takes effect and the run starts from seed_in.
  - RUN:
    - valid=1 and busy=1.
    - Each cycle: pattern←next, cnt←cnt+1 (wraps modulo 2^CNT_W).
    - When n_r≠0 and cnt==n_r-1: go to DONE.
    - stop: go to IDLE the next cycle. No done pulse. Pattern holds its last value. stop has priority over count completion.
  - DONE: done=1, busy=1, valid=0, pattern holds. Go to IDLE the next cycle.
- load_en while busy=1 is ignored. start outside IDLE is ignored.
- wrap=1 in any RUN cycle where next==seed_r. It is combinational from registered state, so it is registered-clean.
- Reset values: state=IDLE, poly_r=DEF_POLY, seed_r=DEF_SEED, pattern=DEF_SEED, cnt=0, n_r=0, busy=0, valid=0, done=0, wrap=0, lockup=0.
- Reset mid-run: immediate return to the reset values. Loaded poly/seed are lost.

## Timing
- start is sampled at edge T. The first pattern (the seed) is presented with valid=1 in cycle T+1.
- A run of N patterns gives valid high for exactly N consecutive cycles, and done in the cycle after the last pattern.
- busy rises with the first valid and falls one cycle after done.
- Back-to-back runs: start asserted in the first IDLE cycle gives at least 2 cycles with valid=0 between runs (the DONE cycle plus the IDLE cycle).
- Load latency: pattern shows seed_in in the cycle after load_en.

## Configuration
- LFSR_LOCKUP_GUARD_EN defined:
  - In RUN, if pattern==0, the next state is seed_r instead of next.
  - lockup pulses for that cycle.
  - cnt still increments.
- LFSR_LOCKUP_GUARD_EN not defined:
  - No detection. An all-zero state persists, which is the legal LFSR behaviour.
  - lockup is tied to 0.

## Test plan
- Reset then start with num_patterns=3, default parameters: valid is high for 3 cycles with patterns 8'h01, then next(8'h01) and next(next(8'h01)); done is high on the 4th cycle; busy is low on the 5th cycle.
- BITS=4, GALOIS=0, load poly=4'b1001, seed=4'b1000, num_patterns=0: pattern sequence is 1000,1100,1110,1111,0111,1011,0101,1010,1101,0110,0011,1001,0100,0010,0001, then repeats; wrap pulses when 0001 is presented.
- stop asserted during the 5th valid cycle of a 10-pattern run: the next cycle is IDLE, there is no done pulse, and pattern holds its value.
- Asynchronous reset pulse mid-run (between edges): busy, valid and done go to 0 immediately and pattern returns to DEF_SEED.
- load_en while busy is ignored: poly_r and seed_r are unchanged after the run; load_en with start in IDLE starts from seed_in.
- With LFSR_LOCKUP_GUARD_EN defined, load seed=0 and start: the first pattern is 0, lockup pulses, and the second pattern is 0 again (seed_r=0). Repeat with poly=0, seed=4'b0001 in Fibonacci mode: the state becomes 0 and is reloaded to 0001 with lockup=1.
